quad_gen: RTL and testbench

- Quadrature pulse generator: the transmit end of the A/B encoder interface.
- Drives a/b lines so that a quadrature counter on the far end moves from the current position to a commanded target, one Gray-code transition at a time.
- Step rate is set by a programmable clock divider.
- Used to emulate spinners/trackballs toward JAMMA inputs and as a loopback stimulus for the quadrature counter.

---
 rtl/quad_gen.sv | 86 ++++++++
 tb/tb_quad_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_gen.sv
// quad_gen: quadrature A/B pulse generator that walks pos toward a commanded target
// one Gray-code transition per divider period, taking the shortest path modulo 2^CNT_W.
module quad_gen #(
  parameter int CNT_W = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ena,
  input  logic             load,
  input  logic             stop,
  input  logic [CNT_W-1:0] target,
  input  logic [DIV_W-1:0] period,
  output logic             a,
  output logic             b,
  output logic [CNT_W-1:0] pos,
  output logic             dir,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [CNT_W-1:0] one = CNT_W'(1);
  localparam logic [DIV_W-1:0] dec = DIV_W'(1);
  state_t state, state_nx;
  logic [CNT_W-1:0] tgt, tgt_nx, pos_nx, t, diff, step_pos;
  logic [DIV_W-1:0] div, div_nx;
  logic dir_nx, done_r, done_nx, fwd;
  // a load in the stepping cycle retargets that very step
  assign t = load ? target : tgt;
  assign diff = t - pos;
  assign fwd = ~diff[CNT_W-1];
  assign step_pos = fwd ? pos + one : pos - one;
  assign busy = state == RUN;
  assign done = done_r & ena;
  always_comb begin
    state_nx = state;
    tgt_nx = tgt;
    pos_nx = pos;
    div_nx = div;
    dir_nx = dir;
    done_nx = 1'b0;
    if (stop) state_nx = IDLE;
    else if (state == IDLE) begin
      if (load) begin
        tgt_nx = target;
        div_nx = period;
        done_nx = target == pos;
        state_nx = target == pos ? IDLE : RUN;
      end
    end else begin
      if (load) tgt_nx = target;
      if (load && target == pos) begin
        state_nx = IDLE;
        done_nx = 1'b1;
      end else if (div != '0) div_nx = div - dec;
      else begin
        pos_nx = step_pos;
        dir_nx = fwd;
        div_nx = period;
        done_nx = step_pos == t;
        state_nx = step_pos == t ? IDLE : RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      tgt <= '0;
      pos <= '0;
      div <= '0;
      dir <= 1'b1;
      done_r <= 1'b0;
      a <= 1'b0;
      b <= 1'b0;
    end else if (ena) begin
      state <= state_nx;
      tgt <= tgt_nx;
      pos <= pos_nx;
      div <= div_nx;
      dir <= dir_nx;
      done_r <= done_nx;
      a <= pos_nx[0] ^ pos_nx[1];
      b <= pos_nx[1];
    end else done_r <= 1'b0;
  end
endmodule

// File: tb/tb_quad_gen.sv
// tb_quad_gen: vector table, directed corner sequences and random stimulus against a spec-level model.
module tb_quad_gen;
  logic clk = 0, reset_n = 0, ena = 0, load = 0, stop = 0;
  logic [3:0] target = 0;
  logic [15:0] period = 0;
  logic a, b, dir, busy, done;
  logic [3:0] pos;
  int checks = 0, errors = 0;
  int m_pos, m_tgt, m_wait;
  bit m_busy, m_dir, m_done_r;
  logic [1:0] ab_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  typedef struct {
    logic ena, load, stop;
    logic [3:0] tgt;
    logic [15:0] per;
    logic [3:0] e_pos;
    logic [1:0] e_ab;
    logic e_busy, e_done;
  } vec_t;
  vec_t vt [11];

  quad_gen #(.CNT_W(4), .DIV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .ena(ena), .load(load), .stop(stop),
    .target(target), .period(period), .a(a), .b(b), .pos(pos),
    .dir(dir), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_pos = 0; m_tgt = 0; m_wait = 0; m_busy = 0; m_dir = 1; m_done_r = 0;
  endfunction

  function automatic void model_edge();
    int d;
    if (!ena) begin
      m_done_r = 0;
      return;
    end
    m_done_r = 0;
    if (stop) m_busy = 0;
    else if (!m_busy) begin
      if (load) begin
        m_tgt = target;
        m_wait = period;
        if (target == m_pos) m_done_r = 1;
        else m_busy = 1;
      end
    end else begin
      if (load) m_tgt = target;
      if (load && target == m_pos) begin
        m_busy = 0;
        m_done_r = 1;
      end else if (m_wait > 0) m_wait--;
      else begin
        d = (m_tgt - m_pos + 16) % 16;
        m_dir = d < 8;
        m_pos = (m_pos + (m_dir ? 1 : 15)) % 16;
        m_wait = period;
        if (m_pos == m_tgt) begin
          m_busy = 0;
          m_done_r = 1;
        end
      end
    end
  endfunction

  task automatic check_all();
    chk("pos", pos, m_pos);
    chk("ab", {a, b}, ab_tab[m_pos]);
    chk("dir", dir, m_dir);
    chk("busy", busy, m_busy);
    chk("done", done, m_done_r && ena);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic move(input int tg, input int per, output int steps, output int dones);
    int prev, n;
    steps = 0;
    target = tg[3:0];
    period = per[15:0];
    load = 1;
    tick();
    load = 0;
    dones = done;
    n = 0;
    while (m_busy && n < 300) begin
      prev = m_pos;
      tick();
      if (m_pos != prev) steps++;
      dones += done;
      n++;
    end
    chk("move_bounded", n < 300, 1);
  endtask

  initial begin
    int s, dn, n;
    vt[0]  = '{1'b1, 1'b1, 1'b0, 4'd3, 16'd2, 4'd0, 2'b00, 1'b1, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd0, 2'b00, 1'b1, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd0, 2'b00, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd1, 2'b10, 1'b1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd1, 2'b10, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd1, 2'b10, 1'b1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd2, 2'b11, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd2, 2'b11, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd2, 2'b11, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd3, 2'b01, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 4'd3, 16'd2, 4'd3, 2'b01, 1'b0, 1'b0};
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_pos", pos, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dir", dir, 1);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < 11; i++) begin
      ena = vt[i].ena; load = vt[i].load; stop = vt[i].stop;
      target = vt[i].tgt; period = vt[i].per;
      tick();
      chk("tv_pos", pos, vt[i].e_pos);
      chk("tv_ab", {a, b}, vt[i].e_ab);
      chk("tv_busy", busy, vt[i].e_busy);
      chk("tv_done", done, vt[i].e_done);
    end
    load = 0;
    move(1, 0, s, dn);
    chk("at1_pos", pos, 1);
    move(14, 0, s, dn);
    chk("wrap_pos", pos, 14);
    chk("wrap_dir", dir, 0);
    chk("wrap_steps", s, 3);
    chk("wrap_dones", dn, 1);
    move(0, 0, s, dn);
    move(8, 1, s, dn);
    chk("tie_steps", s, 8);
    chk("tie_pos", pos, 8);
    chk("tie_dir", dir, 0);
    move(0, 0, s, dn);
    chk("back0_steps", s, 8);
    period = 0; target = 6; load = 1;
    tick();
    load = 0;
    tick();
    chk("rt_pos1", pos, 1);
    target = 2; load = 1;
    tick();
    load = 0;
    dn = done;
    chk("rt_pos", pos, 2);
    chk("rt_busy", busy, 0);
    repeat (3) begin
      tick();
      dn += done;
    end
    chk("rt_done_count", dn, 1);
    target = 6; load = 1;
    tick();
    load = 0;
    tick();
    tick();
    chk("st_pos", pos, 4);
    stop = 1;
    tick();
    stop = 0;
    chk("st_busy", busy, 0);
    chk("st_done", done, 0);
    repeat (3) tick();
    chk("st_ab", {a, b}, 2'b00);
    chk("st_pos_hold", pos, 4);
    target = 6; period = 2; load = 1;
    tick();
    load = 0;
    n = 1;
    tick();
    ena = 0;
    repeat (5) begin
      tick();
      n++;
      chk("gate_ab", {a, b}, 2'b00);
      chk("gate_done", done, 0);
    end
    ena = 1;
    while (!done && n < 40) begin
      tick();
      n++;
    end
    chk("gate_done_cycle", n, 11);
    chk("gate_pos", pos, 6);
    target = 6; load = 1;
    tick();
    load = 0;
    chk("null_done", done, 1);
    chk("null_busy", busy, 0);
    chk("null_ab", {a, b}, 2'b11);
    tick();
    chk("null_done_clear", done, 0);
    target = 10; period = 1; load = 1;
    tick();
    load = 0;
    repeat (5) tick();
    chk("mr_moving", busy, 1);
    #2 reset_n = 0;
    model_reset();
    #1;
    chk("mr_pos", pos, 0);
    chk("mr_ab", {a, b}, 2'b00);
    chk("mr_busy", busy, 0);
    @(negedge clk);
    reset_n = 1;
    tick();
    for (int i = 0; i < 800; i++) begin
      ena = $urandom_range(0, 99) < 85;
      load = $urandom_range(0, 99) < 12;
      stop = $urandom_range(0, 99) < 3;
      target = 4'($urandom_range(0, 15));
      period = 16'($urandom_range(0, 3));
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
